rocket_mover: RTL and testbench
===============================

# rocket_mover

Per-rocket motion engine at the receiving end of the rocket launch interface. Each instance watches one `isActive` flag from the rockets controller. On a rising edge it captures the launch bundle (`initialSpeed`, `initialX`, `initialY`). It then moves the rocket vertically once per frame in 11.6 fixed point and reports border exits back to the controller. It also runs a short explosion phase after a collision and drives the rocket drawing/collision logic with a top-left coordinate and a visibility flag.

## Interface
- `TOP_BORDER`, default 0: topmost visible pixel row.
- `BOTTOM_BORDER`, default 479: bottommost visible pixel row.
- `ROCKET_HEIGHT`, default 16: rocket sprite height in pixels.
- `X_OFFSET`, default 14: added to `initialX` to centre the rocket on its shooter.
- `EXPLODE_FRAMES`, default 8: frame count of the explosion phase.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle pulse per frame.
- `isActive`  in  1  level from the controller; a rising edge launches the rocket.
- `initialSpeed`  in  9 signed  vertical speed in pixels/64 per frame; negative means up.
- `initialX`  in  11 signed  launch X.
- `initialY`  in  11 signed  launch Y.
- `collision`  in  1  rocket pixel overlapped a target this cycle.
- `topLeftX`  out  11 signed  rocket X.
- `topLeftY`  out  11 signed  rocket Y, integer part.
- `rocketVisible`  out  1  high in FLYING and EXPLODING.
- `exploding`  out  1  high in EXPLODING.
- `reachedBorder`  out  1  one-cycle pulse when the rocket leaves the screen.

## Operation
- **States.** IDLE, FLYING, EXPLODING.
- **Edge detect.**
  - `isActive_q` is a registered copy of `isActive`; it resets to 0.
  - `launch = isActive & ~isActive_q`.
- **Position register.**
  - `posY` is 17-bit signed: 11 integer bits plus 6 fraction bits.
  - `topLeftY = posY >>> 6`, an arithmetic shift, so it floors.
  - `topLeftX` is 11 bits and is set only at launch.
- **Launch (any state).** Launch has the highest priority after reset.
  - `topLeftX <= initialX + X_OFFSET`.
  - `posY <= initialY << 6`.
  - `speed <= initialSpeed`, sign-extended to 17 bits.
  - Explosion counter clears; state becomes FLYING.
- **FLYING.** Priority order: launch > collision > startOfFrame > isActive low.
  - `collision`: go to EXPLODING with the counter set to `EXPLODE_FRAMES`. The position freezes, and no move happens even if `startOfFrame` is high in the same cycle.
  - `startOfFrame`: compute `nextY = posY + speed` and `n = nextY >>> 6`.
    - If `n + ROCKET_HEIGHT <= TOP_BORDER` or `n > BOTTOM_BORDER`: pulse `reachedBorder`, go to IDLE, and still load `posY <= nextY`.
    - Otherwise load `posY <= nextY`.
  - `isActive` low with no other event: go to IDLE silently. This is a controller cancel, so there is no `reachedBorder` pulse.
- **EXPLODING.**
  - Each `startOfFrame` decrements the counter.
  - When the counter goes from 1 to 0, go to IDLE.
  - `isActive` falling is ignored here, because the controller drops it on a hit.
  - `collision` is ignored.
- **IDLE.**
  - Outputs hold their last position; `rocketVisible = 0`.
  - `collision` and `startOfFrame` are ignored.
- **Arithmetic.**
  - Speed magnitude is at most 256/64 = 4 px/frame, and the borders lie within ±1023, so `posY` never wraps.
  - No saturation logic is required.

## Timing
- **Reset values.** State IDLE; `topLeftX = 0`, `topLeftY = 0`, `rocketVisible = 0`, `exploding = 0`, `reachedBorder = 0`; `isActive_q = 0`.
- **Launch latency.** If `isActive` rises at edge N, the captured position and `rocketVisible = 1` are valid after edge N+1. The bundle is sampled in the same cycle that `isActive` is first seen high.
- **Move latency.** `startOfFrame` sampled at edge N gives the new `topLeftY` after edge N+1.
- **`reachedBorder`.** Registered and high for exactly one cycle. It is coincident with `rocketVisible` falling.
- **`exploding`.** Rises one cycle after `collision` is sampled. It lasts until the edge after the `EXPLODE_FRAMES`-th subsequent `startOfFrame`.
- **Reset mid-operation.** Asynchronous return to the reset values. A rocket launches again only on a fresh rising edge of `isActive`.

## Configuration
- Macro: `ROCKET_EXPLODE_EN`.
- **Defined.** EXPLODING state exists as described above.
- **Undefined.**
  - EXPLODING is not built and `exploding` is tied to 0.
  - A `collision` in FLYING goes directly to IDLE on the next edge, with no `reachedBorder` pulse.
  - `EXPLODE_FRAMES` is unused.

## Test plan
- **Launch and move.** `initialX = 300`, `initialY = 440`, `initialSpeed = -128`, rising `isActive` → (`topLeftX`, `topLeftY`) = (314, 440) and `rocketVisible = 1`. After 1 SOF, `topLeftY = 438`; after 10 SOFs, 420.
- **Fraction.** `initialY = 100`, `initialSpeed = -32` → `topLeftY` reads 99, 99, 98 after SOF 1, 2 and 3.
- **Top border.** `initialY = 4`, `initialSpeed = -128` → `reachedBorder` pulses once in the cycle after the 10th SOF (y = -16). `rocketVisible` drops in that same cycle, and the state stays IDLE on later SOFs.
- **Collision, macro defined.** After 3 SOFs, assert `collision` together with SOF → y is frozen at its prior value and `exploding = 1` for 8 SOFs, then `rocketVisible = 0`. Dropping `isActive` meanwhile has no effect.
- **Collision, macro undefined.** `collision` in FLYING → `rocketVisible = 0` next cycle; `exploding` and `reachedBorder` stay 0.
- **Reset mid-flight, then relaunch.** Assert `reset` mid-flight → all outputs are 0 immediately. With `isActive` held high through reset release, there is no launch until `isActive` toggles low and then high.

Source files
------------

// File: rtl/rocket_mover_if.sv
// rtl/rocket_mover_if.sv - launch bundle, frame/collision inputs and rocket position outputs
interface rocket_mover_if;
  logic              startOfFrame;
  logic              isActive;
  logic signed [8:0] initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic              collision;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic              rocketVisible;
  logic              exploding;
  logic              reachedBorder;

  // controller / drawing side
  modport master (
    output startOfFrame, isActive, initialSpeed, initialX, initialY, collision,
    input  topLeftX, topLeftY, rocketVisible, exploding, reachedBorder
  );

  // rocket motion engine side
  modport slave (
    input  startOfFrame, isActive, initialSpeed, initialX, initialY, collision,
    output topLeftX, topLeftY, rocketVisible, exploding, reachedBorder
  );
endinterface

// File: rtl/rocket_mover.sv
// rtl/rocket_mover.sv - per-rocket vertical motion engine, 11.6 fixed point; ROCKET_EXPLODE_EN builds the explosion phase
module rocket_mover #(
  parameter int TOP_BORDER     = 0,
  parameter int BOTTOM_BORDER  = 479,
  parameter int ROCKET_HEIGHT  = 16,
  parameter int X_OFFSET       = 14,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic           clk,
  input  logic           reset,
  rocket_mover_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
`ifdef ROCKET_EXPLODE_EN
    EXPLODING = 2'd2,
`endif
    FLYING    = 2'd1
  } state_t;

  localparam logic signed [12:0] TOP_S    = 13'(TOP_BORDER);
  localparam logic signed [12:0] BOTTOM_S = 13'(BOTTOM_BORDER);
  localparam logic signed [12:0] HEIGHT_S = 13'(ROCKET_HEIGHT);
  localparam logic signed [10:0] X_OFF_S  = 11'(X_OFFSET);

  state_t             state, stateNext;
  logic               isActive_q;
  // Cleared by reset and set once isActive has been seen low, so that a level
  // held high across reset release is not mistaken for a fresh launch.
  logic               armed;
  logic signed [10:0] topLeftX_r, topLeftXNext;
  logic signed [16:0] posY, posYNext;
  logic signed [16:0] speed, speedNext;
  logic               reachedBorder_r, reachedBorderNext;

`ifdef ROCKET_EXPLODE_EN
  localparam int CNT_W = (EXPLODE_FRAMES < 2) ? 1 : $clog2(EXPLODE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXPLODE_FRAMES);
  logic [CNT_W-1:0]   cnt, cntNext;
`endif

  logic               launch;
  logic signed [16:0] nextY;
  logic signed [10:0] nInt;
  logic signed [12:0] nExt;
  logic               leaveScreen;

  assign launch      = bus.isActive & ~isActive_q & armed;
  assign nextY       = posY + speed;
  assign nInt        = nextY[16:6];
  assign nExt        = {{2{nInt[10]}}, nInt};
  assign leaveScreen = ((nExt + HEIGHT_S) <= TOP_S) || (nExt > BOTTOM_S);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // next state and next datapath values: launch beats everything, then per-state events
  always_comb begin
    stateNext         = state;
    topLeftXNext      = topLeftX_r;
    posYNext          = posY;
    speedNext         = speed;
    reachedBorderNext = 1'b0;
`ifdef ROCKET_EXPLODE_EN
    cntNext           = cnt;
`endif
    if (launch) begin
      topLeftXNext = bus.initialX + X_OFF_S;
      posYNext     = {bus.initialY, 6'b0};
      speedNext    = {{8{bus.initialSpeed[8]}}, bus.initialSpeed};
`ifdef ROCKET_EXPLODE_EN
      cntNext      = '0;
`endif
      stateNext    = FLYING;
    end else begin
      case (state)
        FLYING: begin
          if (bus.collision) begin
`ifdef ROCKET_EXPLODE_EN
            cntNext   = CNT_LOAD;
            stateNext = EXPLODING;
`else
            stateNext = IDLE;
`endif
          end else if (bus.startOfFrame) begin
            posYNext = nextY;
            if (leaveScreen) begin
              reachedBorderNext = 1'b1;
              stateNext         = IDLE;
            end
          end else if (!bus.isActive) begin
            stateNext = IDLE;
          end
        end
`ifdef ROCKET_EXPLODE_EN
        EXPLODING: begin
          if (bus.startOfFrame) begin
            cntNext = cnt - 1'b1;
            if (cnt == CNT_W'(1)) stateNext = IDLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // datapath registers, edge detector and border pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isActive_q      <= 1'b0;
      armed           <= 1'b0;
      topLeftX_r      <= '0;
      posY            <= '0;
      speed           <= '0;
      reachedBorder_r <= 1'b0;
`ifdef ROCKET_EXPLODE_EN
      cnt             <= '0;
`endif
    end else begin
      isActive_q      <= bus.isActive;
      armed           <= armed | ~bus.isActive;
      topLeftX_r      <= topLeftXNext;
      posY            <= posYNext;
      speed           <= speedNext;
      reachedBorder_r <= reachedBorderNext;
`ifdef ROCKET_EXPLODE_EN
      cnt             <= cntNext;
`endif
    end
  end

  assign bus.topLeftX      = topLeftX_r;
  assign bus.topLeftY      = posY[16:6];
  assign bus.rocketVisible = (state != IDLE);
  assign bus.reachedBorder = reachedBorder_r;
`ifdef ROCKET_EXPLODE_EN
  assign bus.exploding     = (state == EXPLODING);
`else
  assign bus.exploding     = 1'b0;
`endif

endmodule

// File: tb/tb_rocket_mover.sv
// tb/tb_rocket_mover.sv - directed vector bench for rocket_mover
module tb_rocket_mover;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rocket_mover_if bus();

  rocket_mover dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic              sof;
    logic              act;
    logic              col;
    logic signed [8:0] spd;
    logic signed [10:0] x;
    logic signed [10:0] y;
    int                ex;
    int                ey;
    int                ev;
    int                ee;
    int                erb;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int ex, input int ey,
                           input int ev, input int ee, input int erb);
    chk({tag, " topLeftX"},      int'(bus.topLeftX), ex);
    chk({tag, " topLeftY"},      int'(bus.topLeftY), ey);
    chk({tag, " rocketVisible"}, int'(bus.rocketVisible), ev);
    chk({tag, " exploding"},     int'(bus.exploding), ee);
    chk({tag, " reachedBorder"}, int'(bus.reachedBorder), erb);
  endtask

  task automatic add(input logic sof, input logic act, input logic col,
                     input int spd, input int x, input int y,
                     input int ex, input int ey, input int ev, input int ee, input int erb);
    vec_t v;
    v.sof = sof; v.act = act; v.col = col;
    v.spd = 9'(spd); v.x = 11'(x); v.y = 11'(y);
    v.ex = ex; v.ey = ey; v.ev = ev; v.ee = ee; v.erb = erb;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic sof, input logic act, input logic col,
                       input int spd, input int x, input int y);
    bus.startOfFrame = sof;
    bus.isActive     = act;
    bus.collision    = col;
    bus.initialSpeed = 9'(spd);
    bus.initialX     = 11'(x);
    bus.initialY     = 11'(y);
  endtask

  initial begin
    // arm the launch detector
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // launch and move: 2 px/frame upward
    add(0, 1, 0, -128, 300, 440, 314, 440, 1, 0, 0);
    for (int k = 1; k <= 10; k++) add(1, 1, 0, -128, 300, 440, 314, 440 - 2 * k, 1, 0, 0);
    // controller cancel, no border pulse
    add(0, 0, 0, -128, 300, 440, 314, 420, 0, 0, 0);
    // fractional speed of half a pixel per frame
    add(0, 1, 0, -32, 0, 100, 14, 100, 1, 0, 0);
    add(1, 1, 0, -32, 0, 100, 14, 99, 1, 0, 0);
    add(1, 1, 0, -32, 0, 100, 14, 99, 1, 0, 0);
    add(1, 1, 0, -32, 0, 100, 14, 98, 1, 0, 0);
    add(0, 0, 0, -32, 0, 100, 14, 98, 0, 0, 0);
    // top border exit at y = -16
    add(0, 1, 0, -128, 0, 4, 14, 4, 1, 0, 0);
    for (int k = 1; k <= 9; k++) add(1, 1, 0, -128, 0, 4, 14, 4 - 2 * k, 1, 0, 0);
    add(1, 1, 0, -128, 0, 4, 14, -16, 0, 0, 1);
    add(1, 1, 0, -128, 0, 4, 14, -16, 0, 0, 0);
    add(0, 0, 0, -128, 0, 4, 14, -16, 0, 0, 0);
    // bottom border exit at y = 480
    add(0, 1, 0, 128, 0, 476, 14, 476, 1, 0, 0);
    add(1, 1, 0, 128, 0, 476, 14, 478, 1, 0, 0);
    add(1, 1, 0, 128, 0, 476, 14, 480, 0, 0, 1);
    add(0, 0, 0, 128, 0, 476, 14, 480, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    check_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].sof, tbl[i].act, tbl[i].col, tbl[i].spd, tbl[i].x, tbl[i].y);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ev, tbl[i].ee, tbl[i].erb);
    end

    // collision after three frames, together with a frame pulse
    drive(0, 1, 0, -64, 10, 200);
    tick();
    check_out("col launch", 24, 200, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 0, -64, 10, 200);
      tick();
      check_out($sformatf("col sof%0d", k), 24, 200 - k, 1, 0, 0);
    end
    drive(1, 1, 1, -64, 10, 200);
    tick();
`ifdef ROCKET_EXPLODE_EN
    check_out("col hit", 24, 197, 1, 1, 0);
    drive(0, 0, 0, -64, 10, 200);
    tick();
    check_out("col drop act", 24, 197, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, (k == 2), -64, 10, 200);
      tick();
      if (k < 8) check_out($sformatf("expl%0d", k), 24, 197, 1, 1, 0);
      else       check_out("expl end", 24, 197, 0, 0, 0);
    end
    drive(0, 0, 0, -64, 10, 200);
    tick();
    check_out("expl after", 24, 197, 0, 0, 0);
`else
    check_out("col hit", 24, 197, 0, 0, 0);
    drive(1, 1, 0, -64, 10, 200);
    tick();
    check_out("col after", 24, 197, 0, 0, 0);
    drive(0, 0, 0, -64, 10, 200);
    tick();
`endif

    // reset mid-flight with isActive held high, then relaunch
    drive(0, 0, 0, -64, 50, 300);
    tick();
    drive(0, 1, 0, -64, 50, 300);
    tick();
    check_out("rst launch", 64, 300, 1, 0, 0);
    drive(1, 1, 0, -64, 50, 300);
    tick();
    check_out("rst sof", 64, 299, 1, 0, 0);
    drive(0, 1, 0, -64, 50, 300);
    reset = 1'b1;
    #1;
    check_out("rst async", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("rst held%0d", k), 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, -64, 50, 300);
    tick();
    check_out("rst act low", 0, 0, 0, 0, 0);
    drive(0, 1, 0, -64, 50, 300);
    tick();
    check_out("rst relaunch", 64, 300, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
